// File: rtl/sayac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sayac_pkg
//  Description : Shared constants for the sayac_mod counter family and a
//                binary-to-Gray helper function usable by reference models.
//  Contents    : MODE_WRAP / MODE_SAT  - values of the 'mode' input
//                DIR_UP / DIR_DOWN     - values of the 'up' input
//                bin2gray()            - 32-bit binary to Gray conversion
//  Revision    : 1.0 - initial release
// ============================================================================
package sayac_pkg;

    // Values of the 'mode' input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Values of the 'up' input.
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Reflected binary Gray code of a value of up to 32 bits. Callers with
    // narrower values zero-extend and take the low bits of the result; the
    // upper bits stay zero, so truncation is exact.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage : sayac_pkg
`default_nettype wire

// File: rtl/sayac_mod_bin2gray.sv
`default_nettype none
// ============================================================================
//  Module      : bin2gray
//  Description : Purely combinational W-bit binary to Gray code converter.
//  Parameters  : W       - data width in bits
//  Ports       : i_bin   in  W  binary value
//                o_gray  out W  Gray code of i_bin
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2gray #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    // Each Gray bit is the XOR of the binary bit and its more significant
    // neighbour; the MSB passes straight through (shift brings in a zero).
    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule : bin2gray
`default_nettype wire

// File: rtl/sayac_mod.sv
`default_nettype none
// ============================================================================
//  Module      : sayac_mod
//  Description : Parametrised modulo-MOD up/down counter with enable,
//                parallel load (clamped to MOD-1), wrap or saturate mode,
//                registered terminal-count pulse, sticky overflow flag and a
//                Gray-coded copy of the count.
//  Parameters  : W        - counter width in bits
//                the modulus parameter is legal from 2 up to 2**W and the
//                count runs from 0 to one less than the modulus
//  Ports       : clk      in  1  rising-edge clock
//                rst      in  1  synchronous reset, active-high
//                en       in  1  count enable
//                up       in  1  1 = increment, 0 = decrement
//                mode     in  1  0 = wrap, 1 = saturate
//                load     in  1  parallel load strobe (beats en)
//                load_val in  W  value to load
//                clr_ovf  in  1  clears the sticky overflow flag
//                count    out W  registered binary count
//                gray     out W  Gray code of count
//                tc       out 1  registered terminal-count (wrap) pulse
//                ovf      out 1  sticky overflow/underflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sayac_mod
    import sayac_pkg::*;
#(
    parameter int W   = 5,
    parameter int MOD = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         mode,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr_ovf,
    output logic [W-1:0] count,
    output logic [W-1:0] gray,
    output logic         tc,
    output logic         ovf
);

    // ------------------------------------------------------------------------
    // Elaboration-time legality check of the modulus.
    // ------------------------------------------------------------------------
    generate
        if ((MOD < 2) || (MOD > (2 ** W))) begin : g_bad_mod
            $fatal(1, "sayac_mod: MOD=%0d outside legal range [2, 2**W=%0d]",
                   MOD, 2 ** W);
        end
    endgenerate

    // Top of the count range held at exactly W bits. With MOD = 2**W this is
    // all ones, so no comparison ever needs a (W+1)-bit operand.
    localparam logic [W-1:0] C_MAX  = W'(MOD - 1);
    localparam logic [W-1:0] C_ZERO = '0;
    localparam logic [W-1:0] C_ONE  = W'(1);

    logic [W-1:0] r_count;
    logic         r_tc;
    logic         r_ovf;

    logic         w_at_max;
    logic         w_at_zero;
    logic [W-1:0] w_load_clamped;

    assign w_at_max       = (r_count == C_MAX);
    assign w_at_zero      = (r_count == C_ZERO);
    assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

    // ------------------------------------------------------------------------
    // Counter and flag state. Priority: rst > load > en.
    // The ovf set is written after the clear, so a set and a clear in the
    // same cycle leave the flag set.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= C_ZERO;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;

            if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            if (load) begin
                r_count <= w_load_clamped;
            end else if (en) begin
                if (up == DIR_UP) begin
                    if (w_at_max) begin
                        r_ovf <= 1'b1;
                        if (mode == MODE_WRAP) begin
                            r_count <= C_ZERO;
                            r_tc    <= 1'b1;
                        end
                        // Saturate: count holds at C_MAX, no tc.
                    end else begin
                        r_count <= r_count + C_ONE;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_ovf <= 1'b1;
                        if (mode == MODE_WRAP) begin
                            r_count <= C_MAX;
                            r_tc    <= 1'b1;
                        end
                        // Saturate: count holds at zero, no tc.
                    end else begin
                        r_count <= r_count - C_ONE;
                    end
                end
            end
        end
    end

    // Gray output follows the registered count combinationally, so it moves
    // in the same cycle as count.
    bin2gray #(
        .W      (W)
    ) u_bin2gray (
        .i_bin  (r_count),
        .o_gray (gray)
    );

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : sayac_mod
`default_nettype wire
